// File: rtl/multi_road_intersection_ctrl_if.sv
// Command and blacklist-readout bus of the multi-road intersection controller.
// master issues commands/pops, slave is the controller.
interface multi_road_intersection_ctrl_if #(
    parameter int NUM_ROADS = 4,
    parameter int PLATE_W   = 5,
    parameter int BLK_DEPTH = 16
);
    localparam int RW = $clog2(NUM_ROADS);
    localparam int BW = $clog2(BLK_DEPTH + 1);

    logic               cmd_valid;
    logic [1:0]         cmd_op;
    logic [RW-1:0]      cmd_road;
    logic [PLATE_W-1:0] cmd_plate;
    logic               cmd_err;
    logic               blk_rd_en;
    logic [PLATE_W-1:0] blk_plate;
    logic [BW-1:0]      blk_count;
    logic               blk_overflow;

    modport master (
        output cmd_valid, cmd_op, cmd_road, cmd_plate, blk_rd_en,
        input  cmd_err, blk_plate, blk_count, blk_overflow
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_road, cmd_plate, blk_rd_en,
        output cmd_err, blk_plate, blk_count, blk_overflow
    );
endinterface

// File: rtl/multi_road_intersection_ctrl.sv
// Round-robin N-road traffic controller: plate queues, adaptive green, 24h clock,
// red-runner blacklist. Optional pedestrian phase: define INTERSECTION_PED_EN.
module multi_road_intersection_ctrl #(
    parameter int NUM_ROADS   = 4,
    parameter int QUEUE_DEPTH = 16,
    parameter int PLATE_W     = 5,
    parameter int BLK_DEPTH   = 16,
    parameter int GREEN_INIT  = 40,
    parameter int GREEN_STEP  = 5,
    parameter int LO_TH       = 4,
    parameter int HI_TH       = 10,
    parameter int NORM_MIN    = 40,
    parameter int NORM_MAX    = 80,
    parameter int RUSH_MIN    = 30,
    parameter int RUSH_MAX    = 60,
    parameter int START_HOUR  = 6
`ifdef INTERSECTION_PED_EN
    ,
    parameter int PED_TIME    = 15
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    multi_road_intersection_ctrl_if.slave bus,
    output logic [NUM_ROADS-1:0]          green,
    output logic [NUM_ROADS*$clog2(QUEUE_DEPTH+1)-1:0] car_count,
    output logic [6:0]                    remaining_time,
    output logic [4:0]                    hour,
    output logic [5:0]                    minute,
    output logic [5:0]                    second,
    output logic                          rush_hour
`ifdef INTERSECTION_PED_EN
    ,
    input  logic                          ped_req,
    output logic                          ped_walk
`endif
);
    localparam int RW  = $clog2(NUM_ROADS);
    localparam int CW  = $clog2(QUEUE_DEPTH + 1);
    localparam int QPW = $clog2(QUEUE_DEPTH);
    localparam int BW  = $clog2(BLK_DEPTH + 1);
    localparam int BPW = $clog2(BLK_DEPTH);

    typedef enum logic [1:0] {
        S_GREEN,
        S_ALLRED
`ifdef INTERSECTION_PED_EN
        ,
        S_ALLRED_PED,
        S_PED
`endif
    } state_t;

    state_t             state;
    logic [RW-1:0]      cur;
    logic [RW-1:0]      nxt;
    logic [6:0]         dur [NUM_ROADS];
    logic [PLATE_W-1:0] q_mem [NUM_ROADS][QUEUE_DEPTH];
    logic [QPW-1:0]     q_rd [NUM_ROADS];
    logic [QPW-1:0]     q_wr [NUM_ROADS];
    logic [CW-1:0]      q_cnt [NUM_ROADS];
    logic [PLATE_W-1:0] b_mem [BLK_DEPTH];
    logic [BPW-1:0]     b_rd;
    logic [BPW-1:0]     b_wr;
    logic [BW-1:0]      b_cnt;
`ifdef INTERSECTION_PED_EN
    logic               ped_latch;
`endif

    logic               road_ok;
    logic               add_ok;
    logic               rem_ok;
    logic               clr_ok;
    logic               cmd_bad;
    logic               blk_push;
    logic               blk_pop;
    logic               blk_clr;
    logic               push_ok;
    logic               midnight;
    logic [PLATE_W-1:0] head;
    logic [6:0]         exit_dur;
    logic [6:0]         entry_rem;
    logic [4:0]         hour_n;
    logic [5:0]         min_n;
    logic [5:0]         sec_n;
    int                 delta;

    function automatic logic [6:0] clamp_win(input int v, input logic rush);
        int lo;
        int hi;
        int r;
        lo = rush ? RUSH_MIN : NORM_MIN;
        hi = rush ? RUSH_MAX : NORM_MAX;
        r  = (v < lo) ? lo : ((v > hi) ? hi : v);
        return 7'(r);
    endfunction

    function automatic logic is_rush(input logic [4:0] h);
        return (h == 5'd7) || (h == 5'd8) || (h == 5'd17) || (h == 5'd18);
    endfunction

    function automatic logic [QPW-1:0] q_inc(input logic [QPW-1:0] p);
        return (p == QPW'(QUEUE_DEPTH - 1)) ? '0 : p + QPW'(1);
    endfunction

    function automatic logic [BPW-1:0] b_inc(input logic [BPW-1:0] p);
        return (p == BPW'(BLK_DEPTH - 1)) ? '0 : p + BPW'(1);
    endfunction

    always_comb begin
        road_ok  = int'(bus.cmd_road) < NUM_ROADS;
        head     = q_mem[bus.cmd_road][q_rd[bus.cmd_road]];
        add_ok   = bus.cmd_valid && road_ok && (bus.cmd_op == 2'b00)
                   && (q_cnt[bus.cmd_road] != CW'(QUEUE_DEPTH))
                   && (bus.cmd_plate != '0);
        rem_ok   = bus.cmd_valid && road_ok && (bus.cmd_op == 2'b01)
                   && (q_cnt[bus.cmd_road] != '0);
        clr_ok   = bus.cmd_valid && road_ok && (bus.cmd_op == 2'b10);
        cmd_bad  = bus.cmd_valid && !(add_ok || rem_ok || clr_ok);
        // Green bit is the pre-tick value, so a same-cycle tick never excuses a runner
        blk_push = rem_ok && !green[bus.cmd_road];
        midnight = tick && (hour == 5'd23) && (minute == 6'd59)
                   && (second == 6'd59);
        blk_clr  = clr_ok || midnight;
        blk_pop  = bus.blk_rd_en && (b_cnt != '0);
        push_ok  = blk_push && ((b_cnt != BW'(BLK_DEPTH)) || blk_pop);
    end

    always_comb begin
        delta = 0;
        if (int'(q_cnt[cur]) >= HI_TH) delta = GREEN_STEP;
        else if (int'(q_cnt[cur]) <= LO_TH) delta = -GREEN_STEP;
        exit_dur  = clamp_win(int'(dur[cur]) + delta, rush_hour);
        nxt       = (int'(cur) == NUM_ROADS - 1) ? '0 : cur + RW'(1);
        entry_rem = clamp_win(int'(dur[nxt]), rush_hour);
    end

    always_comb begin
        sec_n  = second + 6'd1;
        min_n  = minute;
        hour_n = hour;
        if (second == 6'd59) begin
            sec_n = '0;
            min_n = minute + 6'd1;
            if (minute == 6'd59) begin
                min_n  = '0;
                hour_n = (hour == 5'd23) ? '0 : hour + 5'd1;
            end
        end
    end

    always_comb begin
        car_count = '0;
        for (int r = 0; r < NUM_ROADS; r++) car_count[r*CW +: CW] = q_cnt[r];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_GREEN;
            cur            <= '0;
            green          <= NUM_ROADS'(1);
            remaining_time <= 7'(GREEN_INIT);
            for (int r = 0; r < NUM_ROADS; r++) dur[r] <= 7'(GREEN_INIT);
`ifdef INTERSECTION_PED_EN
            ped_latch      <= 1'b0;
            ped_walk       <= 1'b0;
`endif
        end else begin
            if (tick) begin
                unique case (state)
                    S_GREEN: begin
                        if (remaining_time == 7'd1) begin
                            dur[cur]       <= exit_dur;
                            green          <= '0;
                            remaining_time <= '0;
`ifdef INTERSECTION_PED_EN
                            state <= ped_latch ? S_ALLRED_PED : S_ALLRED;
`else
                            state <= S_ALLRED;
`endif
                        end else begin
                            remaining_time <= remaining_time - 7'd1;
                        end
                    end
                    S_ALLRED: begin
                        cur            <= nxt;
                        green          <= NUM_ROADS'(1) << nxt;
                        remaining_time <= entry_rem;
                        state          <= S_GREEN;
                    end
`ifdef INTERSECTION_PED_EN
                    S_ALLRED_PED: begin
                        state          <= S_PED;
                        ped_walk       <= 1'b1;
                        ped_latch      <= 1'b0;
                        remaining_time <= 7'(PED_TIME);
                    end
                    S_PED: begin
                        if (remaining_time == 7'd1) begin
                            state          <= S_ALLRED;
                            ped_walk       <= 1'b0;
                            remaining_time <= '0;
                        end else begin
                            remaining_time <= remaining_time - 7'd1;
                        end
                    end
`endif
                    default: state <= S_GREEN;
                endcase
            end
`ifdef INTERSECTION_PED_EN
            if (ped_req) ped_latch <= 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_ROADS; r++) begin
                q_rd[r]  <= '0;
                q_wr[r]  <= '0;
                q_cnt[r] <= '0;
                for (int i = 0; i < QUEUE_DEPTH; i++) q_mem[r][i] <= '0;
            end
        end else if (add_ok) begin
            q_mem[bus.cmd_road][q_wr[bus.cmd_road]] <= bus.cmd_plate;
            q_wr[bus.cmd_road]  <= q_inc(q_wr[bus.cmd_road]);
            q_cnt[bus.cmd_road] <= q_cnt[bus.cmd_road] + CW'(1);
        end else if (rem_ok) begin
            q_rd[bus.cmd_road]  <= q_inc(q_rd[bus.cmd_road]);
            q_cnt[bus.cmd_road] <= q_cnt[bus.cmd_road] - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_rd             <= '0;
            b_wr             <= '0;
            b_cnt            <= '0;
            bus.blk_plate    <= '0;
            bus.blk_overflow <= 1'b0;
            for (int i = 0; i < BLK_DEPTH; i++) b_mem[i] <= '0;
        end else if (blk_clr) begin
            // Clear beats any same-cycle push; a same-cycle pop reads as empty
            b_rd  <= '0;
            b_wr  <= '0;
            b_cnt <= '0;
            if (bus.blk_rd_en) bus.blk_plate <= '0;
            if (clr_ok) bus.blk_overflow <= 1'b0;
        end else begin
            if (bus.blk_rd_en) bus.blk_plate <= blk_pop ? b_mem[b_rd] : '0;
            if (blk_pop) b_rd <= b_inc(b_rd);
            if (push_ok) begin
                b_mem[b_wr] <= head;
                b_wr        <= b_inc(b_wr);
            end
            if (blk_push && !push_ok) bus.blk_overflow <= 1'b1;
            b_cnt <= b_cnt + BW'(push_ok) - BW'(blk_pop);
        end
    end

    assign bus.blk_count = b_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.cmd_err <= 1'b0;
        else bus.cmd_err <= cmd_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour      <= 5'(START_HOUR);
            minute    <= '0;
            second    <= '0;
            rush_hour <= is_rush(5'(START_HOUR));
        end else if (tick) begin
            hour      <= hour_n;
            minute    <= min_n;
            second    <= sec_n;
            rush_hour <= is_rush(hour_n);
        end
    end
endmodule

// File: tb/tb_multi_road_intersection_ctrl.sv
// Directed + randomised bench for multi_road_intersection_ctrl,
// checked every cycle against a queue-based reference model.
module tb_multi_road_intersection_ctrl;
    localparam int N  = 4;
    localparam int QD = 16;
    localparam int PW = 5;
    localparam int BD = 16;
    localparam int CW = $clog2(QD + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            tick = 1'b0;
    logic [N-1:0]    green;
    logic [N*CW-1:0] car_count;
    logic [6:0]      remaining_time;
    logic [4:0]      hour;
    logic [5:0]      minute;
    logic [5:0]      second;
    logic            rush_hour;
`ifdef INTERSECTION_PED_EN
    logic            ped_req = 1'b0;
    logic            ped_walk;
`endif

    multi_road_intersection_ctrl_if #(
        .NUM_ROADS(N), .PLATE_W(PW), .BLK_DEPTH(BD)
    ) bus ();

    multi_road_intersection_ctrl #(
        .NUM_ROADS(N), .QUEUE_DEPTH(QD), .PLATE_W(PW), .BLK_DEPTH(BD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick(tick),
        .bus(bus),
        .green(green),
        .car_count(car_count),
        .remaining_time(remaining_time),
        .hour(hour),
        .minute(minute),
        .second(second),
        .rush_hour(rush_hour)
`ifdef INTERSECTION_PED_EN
        ,
        .ped_req(ped_req),
        .ped_walk(ped_walk)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit [PW-1:0] mq [N][$];
    bit [PW-1:0] mb [$];
    int m_road;
    bit m_allred;
    int m_rem;
    int m_dur [N];
    int m_tod;
    bit m_err;
    bit m_ovf;
    int m_plate;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit rush_at(input int tod);
        int h = tod / 3600;
        return (h == 7) || (h == 8) || (h == 17) || (h == 18);
    endfunction

    function automatic int win(input int v, input bit rush);
        int lo = rush ? 30 : 40;
        int hi = rush ? 60 : 80;
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic bit [PW-1:0] rand_plate();
        return PW'($urandom_range(1, 31));
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            mq[k].delete();
            m_dur[k] = 40;
        end
        mb.delete();
        m_road = 0;
        m_allred = 0;
        m_rem = 40;
        m_tod = 6 * 3600;
        m_err = 0;
        m_ovf = 0;
        m_plate = 0;
    endfunction

    function automatic void model_step(input bit t, input bit cv,
                                       input bit [1:0] op, input int road,
                                       input bit [PW-1:0] plate, input bit rd);
        int gr = m_allred ? -1 : m_road;
        bit rush = rush_at(m_tod);
        int n_pre = mq[m_road].size();
        bit push = 0;
        bit clr;
        bit [PW-1:0] pp = '0;
        m_err = 0;
        if (cv) begin
            if (op == 2'd0) begin
                if (mq[road].size() < QD && plate != 0) mq[road].push_back(plate);
                else m_err = 1;
            end else if (op == 2'd1) begin
                if (mq[road].size() > 0) begin
                    pp = mq[road].pop_front();
                    push = (road != gr);
                end else begin
                    m_err = 1;
                end
            end else if (op == 2'd3) begin
                m_err = 1;
            end
        end
        clr = (cv && op == 2'd2) || (t && m_tod == 86399);
        if (clr) begin
            mb.delete();
            if (rd) m_plate = 0;
            if (cv && op == 2'd2) m_ovf = 0;
        end else begin
            if (rd) m_plate = (mb.size() > 0) ? int'(mb.pop_front()) : 0;
            if (push) begin
                if (mb.size() < BD) mb.push_back(pp);
                else m_ovf = 1;
            end
        end
        if (t) begin
            if (!m_allred) begin
                if (m_rem == 1) begin
                    int d = m_dur[m_road];
                    if (n_pre >= 10) d += 5;
                    else if (n_pre <= 4) d -= 5;
                    m_dur[m_road] = win(d, rush);
                    m_allred = 1;
                    m_rem = 0;
                end else begin
                    m_rem--;
                end
            end else begin
                m_road = (m_road + 1) % N;
                m_allred = 0;
                m_rem = win(m_dur[m_road], rush);
            end
            m_tod = (m_tod + 1) % 86400;
        end
    endfunction

    task automatic compare_all();
        check("green", green, m_allred ? 0 : (1 << m_road));
        check("remaining_time", remaining_time, m_rem);
        for (int k = 0; k < N; k++)
            check("car_count", car_count[k*CW +: CW], mq[k].size());
        check("hour", hour, m_tod / 3600);
        check("minute", minute, (m_tod / 60) % 60);
        check("second", second, m_tod % 60);
        check("rush_hour", rush_hour, rush_at(m_tod));
        check("cmd_err", bus.cmd_err, m_err);
        check("blk_count", bus.blk_count, mb.size());
        check("blk_plate", bus.blk_plate, m_plate);
        check("blk_overflow", bus.blk_overflow, m_ovf);
    endtask

    task automatic step(input bit t, input bit cv, input bit [1:0] op,
                        input int road, input bit [PW-1:0] plate, input bit rd);
        tick          = t;
        bus.cmd_valid = cv;
        bus.cmd_op    = op;
        bus.cmd_road  = 2'(road);
        bus.cmd_plate = plate;
        bus.blk_rd_en = rd;
        @(posedge clk);
        model_step(t, cv, op, road, plate, rd);
        #1;
        tick          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.blk_rd_en = 1'b0;
        compare_all();
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1, 0, 2'd0, 0, '0, 0);
    endtask

    task automatic wait_phase(input int road, input bit ar);
        int b = 0;
        do begin
            step(1, 0, 2'd0, 0, '0, 0);
            b++;
        end while (!(m_allred == ar && m_road == road) && b < 2000);
        check("phase_reached", (m_allred == ar && m_road == road), 1);
    endtask

    task automatic rand_step();
        int sel = $urandom_range(0, 99);
        bit [1:0] op = (sel < 50) ? 2'd0 : (sel < 95) ? 2'd1 :
                       (sel < 97) ? 2'd2 : 2'd3;
        bit [PW-1:0] pl = ($urandom_range(0, 15) == 0) ? '0 : rand_plate();
        step($urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0, op,
             $urandom_range(0, N - 1), pl, $urandom_range(0, 4) == 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_road  = '0;
        bus.cmd_plate = '0;
        bus.blk_rd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        compare_all();
        check("rst_green", green, 1);
        check("rst_rem", remaining_time, 40);
        check("rst_hour", hour, 6);

        ticks(39);
        check("t1_green_hold", green, 1);
        ticks(1);
        check("t1_allred", green, 0);
        ticks(1);
        check("t1_road1", green, 2);
        check("t1_rem", remaining_time, 40);

        step(0, 1, 2'd0, 0, 5'd7, 0);
        step(0, 1, 2'd1, 0, '0, 0);
        check("t3_blk_count", bus.blk_count, 1);
        step(0, 0, 2'd0, 0, '0, 1);
        check("t3_blk_plate", bus.blk_plate, 7);
        check("t3_blk_empty", bus.blk_count, 0);

        repeat (12) step(0, 1, 2'd0, 0, rand_plate(), 0);
        wait_phase(0, 0);
        check("t2_first", remaining_time, 40);
        wait_phase(0, 1);
        wait_phase(0, 0);
        check("t2_grow", remaining_time, 45);
        repeat (12) step(0, 1, 2'd1, 0, '0, 0);
        check("t2_green_rm", bus.blk_count, 0);
        wait_phase(0, 1);
        wait_phase(0, 0);
        check("t2_shrink", remaining_time, 40);

        repeat (16) step(0, 1, 2'd0, 2, rand_plate(), 0);
        step(0, 1, 2'd0, 2, 5'd9, 0);
        check("t4_full_err", bus.cmd_err, 1);
        check("t4_full_cnt", car_count[2*CW +: CW], 16);
        step(0, 1, 2'd1, 3, '0, 0);
        check("t4_empty_err", bus.cmd_err, 1);
        step(0, 1, 2'd0, 1, '0, 0);
        check("t4_plate0_err", bus.cmd_err, 1);
        step(0, 1, 2'd3, 1, 5'd5, 0);
        check("t4_op3_err", bus.cmd_err, 1);
        step(0, 0, 2'd0, 0, '0, 0);
        check("t4_err_pulse", bus.cmd_err, 0);

        step(0, 1, 2'd0, 3, 5'd11, 0);
        step(0, 1, 2'd0, 3, 5'd12, 0);
        repeat (16) step(0, 1, 2'd1, 2, '0, 0);
        check("t6_full", bus.blk_count, 16);
        check("t6_no_ovf", bus.blk_overflow, 0);
        step(0, 1, 2'd1, 3, '0, 0);
        check("t6_ovf", bus.blk_overflow, 1);
        check("t6_ovf_cnt", bus.blk_count, 16);
        check("t6_car_gone", car_count[3*CW +: CW], 1);
        step(0, 1, 2'd1, 3, '0, 1);
        check("t6_pushpop_full", bus.blk_count, 16);
        step(0, 1, 2'd2, 0, '0, 0);
        check("t6_clr_cnt", bus.blk_count, 0);
        check("t6_clr_ovf", bus.blk_overflow, 0);
        step(0, 0, 2'd0, 0, '0, 1);
        check("t6_pop_empty", bus.blk_plate, 0);

        for (int g = 0; g < 90000 && m_tod != 86399; g++) rand_step();
        check("t5_reached_2359", m_tod, 86399);
        r = (m_road + 1) % N;
        step(0, 1, 2'd0, r, rand_plate(), 0);
        step(0, 1, 2'd0, r, rand_plate(), 0);
        step(0, 1, 2'd1, r, '0, 0);
        step(1, 1, 2'd1, r, '0, 1);
        check("t5_midnight_h", hour, 0);
        check("t5_midnight_s", second, 0);
        check("t5_midnight_blk", bus.blk_count, 0);
        check("t5_midnight_pop", bus.blk_plate, 0);

        ticks(5);
        step(0, 1, 2'd0, 1, 5'd3, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("async_green", green, 1);
        check("async_cnt1", car_count[1*CW +: CW], 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
